// File: rtl/nn_inference_sequencer.sv
// Control sequencer for a two-layer fully connected network.
// It walks the datapath through every layer-1 and layer-2 dot product.
// It writes the hidden activations back to memory.
// It tracks the best layer-2 score and publishes the winning class index when the run completes.
module nn_inference_sequencer #(
  parameter int N_IN    = 784,
  parameter int N_HID   = 64,
  parameter int N_OUT   = 10,
  parameter int MAC_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] acc_data,
  output logic        mac_en,
  output logic        mac_clear,
  output logic        layer_sel,
  output logic [9:0]  in_addr,
  output logic [15:0] w_addr,
  output logic        wb_en,
  output logic [5:0]  wb_addr,
  output logic        busy,
  output logic        done,
  output logic [3:0]  current_state,
  output logic [3:0]  argmax_output
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    L1_MAC   = 4'd1,
    L1_DRAIN = 4'd2,
    L1_WB    = 4'd3,
    L2_MAC   = 4'd4,
    L2_DRAIN = 4'd5,
    L2_WB    = 4'd6,
    DONE     = 4'd7
  } state_t;

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [9:0]    L1_LAST    = 10'(N_IN - 1);
  localparam logic [9:0]    L2_LAST    = 10'(N_HID - 1);
  localparam logic [5:0]    HID_LAST   = 6'(N_HID - 1);
  localparam logic [5:0]    OUT_LAST   = 6'(N_OUT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);

  state_t state_reg, state_next;

  logic [1:0]         sync_reg;
  logic               start_prev_reg;
  logic               start_event;
  logic [9:0]         i_reg;
  logic [5:0]         n_reg;
  logic [15:0]        w_reg;
  logic [DW-1:0]      drain_reg;
  logic signed [31:0] best_score_reg;
  logic [3:0]         best_idx_reg;
  logic [3:0]         argmax_reg;
  logic               best_update;

  // Two-flop synchroniser on the push-button level, plus a delayed copy used to detect its rising edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_reg       <= 2'b00;
      start_prev_reg <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[0], start};
      start_prev_reg <= sync_reg[1];
    end
  end

  assign start_event = sync_reg[1] & ~start_prev_reg;

  // The first score always wins.
  // After that only a strictly greater score replaces the best, so ties keep the lower index.
  assign best_update = (n_reg == 6'd0) || ($signed(acc_data) > best_score_reg);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start_event) state_next = L1_MAC;
      L1_MAC:     if (i_reg == L1_LAST) state_next = L1_DRAIN;
      L1_DRAIN:   if (drain_reg == DRAIN_LAST) state_next = L1_WB;
      L1_WB:      state_next = (n_reg == HID_LAST) ? L2_MAC : L1_MAC;
      L2_MAC:     if (i_reg == L2_LAST) state_next = L2_DRAIN;
      L2_DRAIN:   if (drain_reg == DRAIN_LAST) state_next = L2_WB;
      L2_WB:      state_next = (n_reg == OUT_LAST) ? DONE : L2_MAC;
      default:    state_next = IDLE;
    endcase
  end

  // Counters, running weight address and argmax tracking.
  // w_reg only ever increments during MAC cycles, which yields n*N + i without a multiplier.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_reg          <= '0;
      n_reg          <= '0;
      w_reg          <= '0;
      drain_reg      <= '0;
      best_score_reg <= '0;
      best_idx_reg   <= '0;
      argmax_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start_event) begin
            i_reg          <= '0;
            n_reg          <= '0;
            w_reg          <= '0;
            drain_reg      <= '0;
            best_score_reg <= '0;
            best_idx_reg   <= '0;
          end
        end
        L1_MAC, L2_MAC: begin
          w_reg     <= w_reg + 16'd1;
          drain_reg <= '0;
          if (i_reg == ((state_reg == L1_MAC) ? L1_LAST : L2_LAST)) i_reg <= '0;
          else                                                      i_reg <= i_reg + 10'd1;
        end
        L1_DRAIN, L2_DRAIN: begin
          drain_reg <= (drain_reg == DRAIN_LAST) ? '0 : drain_reg + DW'(1);
        end
        L1_WB: begin
          i_reg <= '0;
          if (n_reg == HID_LAST) begin
            n_reg <= '0;
            w_reg <= '0;
          end else begin
            n_reg <= n_reg + 6'd1;
          end
        end
        L2_WB: begin
          i_reg <= '0;
          if (best_update) begin
            best_score_reg <= $signed(acc_data);
            best_idx_reg   <= n_reg[3:0];
          end
          // The published index changes only when the last score has been seen
          if (n_reg == OUT_LAST) argmax_reg <= best_update ? n_reg[3:0] : best_idx_reg;
          else                   n_reg      <= n_reg + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Output decode from state and counters; everything collapses to zero in IDLE after reset
  always_comb begin
    mac_en        = 1'b0;
    mac_clear     = 1'b0;
    layer_sel     = 1'b0;
    wb_en         = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    in_addr       = i_reg;
    w_addr        = w_reg;
    wb_addr       = n_reg;
    current_state = state_reg;
    case (state_reg)
      IDLE:     busy = 1'b0;
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      L1_MAC: begin
        mac_en    = 1'b1;
        mac_clear = (i_reg == 10'd0);
      end
      L1_WB:    wb_en = 1'b1;
      L2_MAC: begin
        mac_en    = 1'b1;
        mac_clear = (i_reg == 10'd0);
        layer_sel = 1'b1;
      end
      L2_DRAIN, L2_WB: layer_sel = 1'b1;
      default: ;
    endcase
  end

  assign argmax_output = argmax_reg;

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Directed bench for nn_inference_sequencer with a small network (4-3-10, two-cycle MAC latency).
module tb_nn_inference_sequencer;

  localparam int N_IN    = 4;
  localparam int N_HID   = 3;
  localparam int N_OUT   = 10;
  localparam int MAC_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] acc_data = '0;
  logic        mac_en, mac_clear, layer_sel, wb_en, busy, done;
  logic [9:0]  in_addr;
  logic [15:0] w_addr;
  logic [5:0]  wb_addr;
  logic [3:0]  current_state, argmax_output;

  nn_inference_sequencer #(
    .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .acc_data(acc_data),
    .mac_en(mac_en), .mac_clear(mac_clear), .layer_sel(layer_sel),
    .in_addr(in_addr), .w_addr(w_addr), .wb_en(wb_en), .wb_addr(wb_addr),
    .busy(busy), .done(done), .current_state(current_state),
    .argmax_output(argmax_output)
  );

  always #5 clk = ~clk;

  // One record per inference run: layer-2 scores, expected winner, start style
  // mode 0: short start pulse; 1: start held high the whole run; 2: extra pulse during layer 2
  typedef struct packed {
    logic [9:0][31:0] scores;
    logic [3:0]       exp_idx;
    logic [1:0]       mode;
  } vec_t;

  vec_t tbl [5];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"},     32'(current_state), 0);
    check({tag, "_mac_en"},    32'(mac_en), 0);
    check({tag, "_mac_clear"}, 32'(mac_clear), 0);
    check({tag, "_wb_en"},     32'(wb_en), 0);
    check({tag, "_layer_sel"}, 32'(layer_sel), 0);
    check({tag, "_in_addr"},   32'(in_addr), 0);
    check({tag, "_w_addr"},    32'(w_addr), 0);
    check({tag, "_wb_addr"},   32'(wb_addr), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_argmax"},    32'(argmax_output), 0);
    $display("reset check %s: state=%0d argmax=%0d", tag, current_state, argmax_output);
  endtask

  // Run one full inference, watching every cycle, then compare the totals
  task automatic do_run(input string tag, input vec_t v, input logic [3:0] prev_arg);
    int k, edges, mac_clr, l1i, l2i, l2wb, viol, tr1, tr2, drain_run, repulse;
    int st;
    bit entered;
    int wbq[$];
    k = 0; edges = 0; mac_clr = 0; l1i = 0; l2i = 0; l2wb = 0; viol = 0;
    tr1 = 0; tr2 = 0; drain_run = 0; repulse = 0; entered = 0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    while (k < 10 && !entered) begin
      @(posedge clk); #1;
      k++;
      if (current_state == 4'd1) entered = 1;
    end
    check({tag, "_start_latency"}, k, 3);
    if (v.mode != 2'd1) start = 1'b0;
    while (current_state != 4'd7 && edges < 200) begin
      st = int'(current_state);
      if (mac_en !== (st == 1 || st == 4)) viol++;
      if (wb_en !== (st == 3)) viol++;
      if (mac_clear !== (mac_en && in_addr == 10'd0)) viol++;
      if (busy !== 1'b1 || done !== 1'b0) viol++;
      if (argmax_output !== prev_arg) viol++;
      if (mac_clear) mac_clr++;
      if (st == 1) begin
        if (in_addr !== 10'(l1i % N_IN) || w_addr !== 16'(l1i) || layer_sel !== 1'b0) tr1++;
        l1i++;
      end
      if (st == 4) begin
        if (in_addr !== 10'(l2i % N_HID) || w_addr !== 16'(l2i) || layer_sel !== 1'b1) tr2++;
        l2i++;
      end
      if (st == 2 || st == 5) drain_run++;
      else if (st == 3 || st == 6) begin
        if (drain_run != MAC_LAT) viol++;
        drain_run = 0;
      end
      if (wb_en) wbq.push_back(int'(wb_addr));
      if (st == 6 && l2wb < 10) begin
        acc_data = v.scores[l2wb];
        l2wb++;
      end else begin
        acc_data = $urandom;
      end
      if (v.mode == 2'd2) begin
        if (st == 4 && repulse == 0) begin
          start = 1'b1;
          repulse = 1;
        end else if (repulse > 0 && repulse < 4) begin
          repulse++;
          if (repulse == 4) start = 1'b0;
        end
      end
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_run_edges"}, edges, 81);
    check({tag, "_mac_clear_count"}, mac_clr, 13);
    check({tag, "_l1_mac_cycles"}, l1i, 12);
    check({tag, "_l2_mac_cycles"}, l2i, 30);
    check({tag, "_l1_trace_errs"}, tr1, 0);
    check({tag, "_l2_trace_errs"}, tr2, 0);
    check({tag, "_cycle_violations"}, viol, 0);
    check({tag, "_l2_wb_count"}, l2wb, 10);
    check({tag, "_wb_count"}, wbq.size(), 3);
    for (int j = 0; j < wbq.size() && j < 3; j++)
      check($sformatf("%s_wb_addr%0d", tag, j), wbq[j], j);
    check({tag, "_argmax"}, 32'(argmax_output), 32'(v.exp_idx));
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_stays_done"}, 32'(current_state), 7);
    check({tag, "_argmax_hold"}, 32'(argmax_output), 32'(v.exp_idx));
    $display("run %s: mode=%0d edges=%0d mac_clear=%0d argmax=%0d expected=%0d",
             tag, v.mode, edges, mac_clr, argmax_output, v.exp_idx);
  endtask

  initial begin : main
    int s0[10] = '{-5, 3, 7, 7, -1, 0, 2, 1, 6, 4};
    int k, bad;
    bit found;
    logic [3:0] prev;

    for (int j = 0; j < 10; j++) begin
      tbl[0].scores[j] = 32'(s0[j]);
      tbl[1].scores[j] = 32'(-8 - j);
      tbl[2].scores[j] = 32'(j + 1);
      tbl[3].scores[j] = (j == 5) ? 32'h7fff_ffff : 32'h8000_0000;
      tbl[4].scores[j] = 32'd42;
    end
    tbl[0].exp_idx = 4'd2; tbl[0].mode = 2'd0;
    tbl[1].exp_idx = 4'd0; tbl[1].mode = 2'd1;
    tbl[2].exp_idx = 4'd9; tbl[2].mode = 2'd2;
    tbl[3].exp_idx = 4'd5; tbl[3].mode = 2'd0;
    tbl[4].exp_idx = 4'd0; tbl[4].mode = 2'd0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_without_start", 32'(current_state), 0);

    prev = 4'd0;
    for (int r = 0; r < 5; r++) begin
      do_run($sformatf("vec%0d", r), tbl[r], prev);
      prev = tbl[r].exp_idx;
    end

    // Reset asserted during the layer-1 write-back of neuron 1
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    k = 0; found = 0;
    while (k < 100 && !found) begin
      @(posedge clk); #1;
      k++;
      if (start && current_state == 4'd1) start = 1'b0;
      if (current_state == 4'd3 && wb_addr == 6'd1) found = 1;
    end
    check("midrun_reached_wb1", 32'(found), 1);
    resetn = 1'b0;
    #1;
    check_reset("midrun");
    @(posedge clk); #2;
    resetn = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (wb_en || current_state != 4'd0 || busy) bad++;
    end
    check("post_reset_quiet", bad, 0);
    $display("reset mid-run: quiet cycles with activity=%0d", bad);

    do_run("after_reset", tbl[0], 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench can never hang
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nn_inference_sequencer.md
NN_INFERENCE_SEQUENCER -- requirements
Module: nn_inference_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  N_IN, 784, layer-1 inputs per neuron
  N_HID, 64, layer-1 neurons (= layer-2 inputs)
  N_OUT, 10, layer-2 neurons (argmax candidates)
  MAC_LAT, 2, cycles from last mac_en to acc_data valid
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock; all logic rises on it
  resetn  in  1  asynchronous, active-low reset
  start  in  1  asynchronous level from push-button, active-high
  acc_data  in  32  signed accumulator from datapath
  mac_en  out  1  datapath multiply-accumulates this cycle
  mac_clear  out  1  with mac_en: load product instead of add
  layer_sel  out  1  0 = layer 1, 1 = layer 2
  in_addr  out  10  activation read address (image or hidden)
  w_addr  out  16  weight read address within the selected layer
  wb_en  out  1  write ReLU(acc_data) to hidden[wb_addr]
  wb_addr  out  6  hidden neuron index
  busy  out  1  high in all states except IDLE and DONE
  done  out  1  high while in DONE
  current_state  out  4  FSM state code (drives LED one-hot)
  argmax_output  out  4  winning class index

Function
REQ-003 start SHALL pass a 2-flop synchroniser, then a rising-edge detector; only a synchronised 0->1 edge is a start event.
REQ-004 FSM codes SHALL be: IDLE=0, L1_MAC=1, L1_DRAIN=2, L1_WB=3, L2_MAC=4, L2_DRAIN=5, L2_WB=6, DONE=7.
REQ-005 IDLE or DONE + start event -> L1_MAC; neuron counter n=0, input counter i=0, w_addr=0, best score/index cleared.
REQ-006 L1_MAC: mac_en=1, layer_sel=0, in_addr=i, w_addr=n*N_IN+i (running counter, no multiplier), mac_clear=1 only when i=0; i=N_IN-1 -> L1_DRAIN.
REQ-007 L1_DRAIN SHALL last exactly MAC_LAT cycles with mac_en=0, then -> L1_WB.
REQ-008 L1_WB: single cycle, wb_en=1, wb_addr=n; n<N_HID-1 -> n+1, i=0, L1_MAC; else n=0, w_addr=0, -> L2_MAC.
REQ-009 L2_MAC/L2_DRAIN SHALL mirror REQ-006/007 with layer_sel=1, loop bound N_HID, w_addr=n*N_HID+i.
REQ-010 L2_WB: single cycle, wb_en=0; compare acc_data (signed) with best; update when n=0 or acc_data > best strictly (ties keep lower index); n<N_OUT-1 -> n+1, L2_MAC; else -> DONE.
REQ-011 argmax_output SHALL register best index on the L2_WB->DONE edge only; it holds its previous value throughout a run.
REQ-012 Cycles from L1_MAC entry to DONE entry SHALL equal N_HID*(N_IN+MAC_LAT+1)+N_OUT*(N_HID+MAC_LAT+1).
REQ-013 Start events while busy=1 SHALL be ignored; the level of start is never re-triggering.
REQ-014 mac_en, wb_en, mac_clear SHALL be zero outside their states; addresses are don't-care when their enables are low.

Reset
REQ-015 resetn=0 SHALL asynchronously force IDLE, all counters 0, synchroniser flops 0, and outputs mac_en=0, mac_clear=0, wb_en=0, layer_sel=0, in_addr=0, w_addr=0, wb_addr=0, busy=0, done=0, current_state=0, argmax_output=0.
REQ-016 Reset asserted mid-run SHALL abort with no further wb_en; after release the block waits in IDLE for a fresh start event.

Verification (N_IN=4, N_HID=3, N_OUT=10, MAC_LAT=2)
REQ-017 start pulse -> L1_MAC entered 3rd edge after start rises; done rises 81 edges later; mac_clear high on 13 cycles (3+10).
REQ-018 Layer-1 trace -> in_addr 0,1,2,3 and w_addr 0..3, 4..7, 8..11; wb_en at wb_addr 0,1,2.
REQ-019 acc_data at L2_WB = -5,3,7,7,-1,0,2,1,6,4 -> argmax_output=2 (tie at 3 keeps 2); all negative -8..-17 decreasing -> 0.
REQ-020 start held high entire run, plus second pulse mid-L2 -> single run, one done; start re-pulsed in DONE -> new run, argmax_output unchanged until next DONE.
REQ-021 resetn low during L1_WB of neuron 1 -> all outputs per REQ-015 same cycle; no wb_en after release until new start.
